// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the hazard-FSM state encoding, the operand-forwarding select codes
// and the default register-address width.
package pipe_pkg;

    localparam int unsigned NREG_W = 5;
    localparam int unsigned FW_W   = 2;
    localparam int unsigned ST_W   = 2;

    // Hazard FSM states; encoding 3 is unused and decodes as RUN.
    typedef enum logic [ST_W-1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hcu_state_e;

    // Operand source selects for the EX-stage operand muxes.
    localparam logic [FW_W-1:0] FW_RF  = 2'b00;
    localparam logic [FW_W-1:0] FW_EX  = 2'b01;
    localparam logic [FW_W-1:0] FW_MEM = 2'b10;
    localparam logic [FW_W-1:0] FW_WB  = 2'b11;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID-stage source register.
// Ports:
//   rx_i                 source register number
//   use_i                instruction actually reads this operand
//   ex_/mem_/wb_rd_i     destination register of each later stage
//   ex_/mem_/wb_rf_le_i  that stage will write the register file
//   ex_load_i            EX holds a load (its data is not ready yet)
//   sel_o                FW_RF / FW_EX / FW_MEM / FW_WB
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = NREG_W
) (
    input  logic [REG_W-1:0] rx_i,
    input  logic             use_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_rf_le_i,
    input  logic             ex_load_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_rf_le_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_rf_le_i,
    output logic [FW_W-1:0]  sel_o
);

    // Youngest producer wins; r0 never forwards. A load in EX is skipped so
    // an older MEM/WB value can still be picked (the load-use stall covers it).
    always_comb begin
        sel_o = FW_RF;
        if (use_i && (rx_i != '0)) begin
            if (ex_rf_le_i && !ex_load_i && (ex_rd_i == rx_i)) begin
                sel_o = FW_EX;
            end else if (mem_rf_le_i && (mem_rd_i == rx_i)) begin
                sel_o = FW_MEM;
            end else if (wb_rf_le_i && (wb_rd_i == rx_i)) begin
                sel_o = FW_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
// Compares ID source registers against EX/MEM/WB destinations and drives
// operand forwarding, load-use / branch-operand bubbles and delay-slot
// squashing. LE/S/flush_ifid/fw_* are combinational; the FSM only records
// history (state_out) and the saturating event counters.
// Ports:
//   Clk, Rst                 clock, synchronous active-low reset
//   id_ra/id_rb, id_use_a/b  ID source registers and their use flags
//   id_is_branch             ID branch needs its operands in ID
//   br_taken, br_nullify     branch outcome and nullify bit
//   ex/mem/wb_rd, *_rf_le    stage destinations and write enables
//   ex_load                  EX holds a load
//   LE, S, flush_ifid        PC/IF-ID enable, bubble select, IF/ID squash
//   fw_a, fw_b               operand forwarding selects
//   stall_cnt, flush_cnt     saturating event counters
//   state_out                current FSM state
module hazard_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned NREG_W = pipe_pkg::NREG_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREG_W-1:0] id_ra,
    input  logic [NREG_W-1:0] id_rb,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              id_is_branch,
    input  logic              br_taken,
    input  logic              br_nullify,
    input  logic [NREG_W-1:0] ex_rd,
    input  logic [NREG_W-1:0] mem_rd,
    input  logic [NREG_W-1:0] wb_rd,
    input  logic              ex_rf_le,
    input  logic              mem_rf_le,
    input  logic              wb_rf_le,
    input  logic              ex_load,
    output logic              LE,
    output logic              S,
    output logic              flush_ifid,
    output logic [FW_W-1:0]   fw_a,
    output logic [FW_W-1:0]   fw_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [ST_W-1:0]   state_out
);

    logic [FW_W-1:0]  fwa_raw;
    logic [FW_W-1:0]  fwb_raw;
    logic             ex_writes;
    logic             ex_dep;
    logic             lu;
    logic             nul;
    hcu_state_e       state_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    fwd_sel #(.REG_W(NREG_W)) u_fwd_a (
        .rx_i        (id_ra),
        .use_i       (id_use_a),
        .ex_rd_i     (ex_rd),
        .ex_rf_le_i  (ex_rf_le),
        .ex_load_i   (ex_load),
        .mem_rd_i    (mem_rd),
        .mem_rf_le_i (mem_rf_le),
        .wb_rd_i     (wb_rd),
        .wb_rf_le_i  (wb_rf_le),
        .sel_o       (fwa_raw)
    );

    fwd_sel #(.REG_W(NREG_W)) u_fwd_b (
        .rx_i        (id_rb),
        .use_i       (id_use_b),
        .ex_rd_i     (ex_rd),
        .ex_rf_le_i  (ex_rf_le),
        .ex_load_i   (ex_load),
        .mem_rd_i    (mem_rd),
        .mem_rf_le_i (mem_rf_le),
        .wb_rd_i     (wb_rd),
        .wb_rf_le_i  (wb_rf_le),
        .sel_o       (fwb_raw)
    );

    // ID depends on a live EX result. Loads stall everyone; a branch also
    // stalls on a plain ALU result since it resolves in ID and can only take
    // operands forwarded from MEM onwards.
    assign ex_writes = ex_rf_le && (ex_rd != '0);
    assign ex_dep    = ex_writes && ((id_use_a && (ex_rd == id_ra)) ||
                                     (id_use_b && (ex_rd == id_rb)));
    assign lu        = ex_dep && (ex_load || id_is_branch);

    // A branch seen during a bubble is ignored and re-evaluated afterwards.
    assign nul       = br_taken && br_nullify && !lu;

    // Sequencing outputs; reset pumps NOPs while PC keeps advancing.
    always_comb begin
        LE         = 1'b1;
        S          = 1'b0;
        flush_ifid = 1'b0;
        fw_a       = fwa_raw;
        fw_b       = fwb_raw;
        if (!Rst) begin
            S          = 1'b1;
            flush_ifid = 1'b1;
            fw_a       = FW_RF;
            fw_b       = FW_RF;
        end else if (lu) begin
            LE = 1'b0;
            S  = 1'b1;
        end else if (nul) begin
            flush_ifid = 1'b1;
        end
    end

    // History FSM and saturating counters.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                STALL:   state_q <= lu ? STALL : (nul ? FLUSH : RUN);
                FLUSH:   state_q <= lu ? STALL : (nul ? FLUSH : RUN);
                default: state_q <= lu ? STALL : (nul ? FLUSH : RUN);
            endcase
            if (lu && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (nul && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state_out = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

- Pipeline sequencing controller for the 5-stage PA-RISC core (IF, ID, EX, MEM, WB).
- Each cycle it compares ID-stage source registers with destinations in EX/MEM/WB, then:
  - drives operand-forwarding selects;
  - inserts load-use bubbles by holding PC/NPC and IF/ID (LE) and forcing the CU NOP mux (S);
  - squashes the IF/ID slot on a nullifying taken branch.
- Sits beside the ID stage and replaces the externally driven LE/S used in bring-up benches.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall and flush performance counters
- NREG_W, 5, register-address width (32 GPRs; r0 hardwired zero)

Ports:
- Clk  in  1  single clock, all state on rising edge
- Rst  in  1  synchronous reset, active-low (Rst=0 resets on next Clk edge)
- id_ra, id_rb  in  NREG_W  ID-stage source register numbers
- id_use_a, id_use_b  in  1  instruction in ID actually reads ra / rb
- id_is_branch  in  1  ID holds a conditional branch or BL (operands needed in ID)
- br_taken  in  1  branch in ID resolves taken this cycle
- br_nullify  in  1  nullify bit of that branch (squash the delay slot)
- ex_rd, mem_rd, wb_rd  in  NREG_W  destination register per stage
- ex_rf_le, mem_rf_le, wb_rf_le  in  1  stage will write the RF
- ex_load  in  1  EX holds a load (L=1)
- LE  out  1  load enable for PC, NPC and IF/ID
- S  out  1  1 = CU mux outputs all-zero control (bubble into EX)
- flush_ifid  out  1  IF/ID loads a NOP instead of the fetched word
- fw_a, fw_b  out  2  operand select: 00 RF, 01 EX, 10 MEM, 11 WB
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters
- state_out  out  2  current FSM state, for debug

## Operation
- Forwarding, per operand X ∈ {a, b}:
  - fw_x=00 if use_x=0 or rx=0.
  - Otherwise, first match in order EX (rf_le, rd==rx, ex_load=0) → 01, MEM → 10, WB → 11, else 00.
- Load-use hazard `lu` = ex_load & ex_rf_le & ex_rd≠0 & ((id_use_a & ex_rd==id_ra) | (id_use_b & ex_rd==id_rb)).
- Branch-operand hazard: id_is_branch and any operand match in EX with ex_rf_le (even when not a load) also raises `lu`. The condition must come from at least MEM.
- Effective taken: `tk` = br_taken & ~lu. A branch seen during a hazard is ignored and re-evaluated after the bubble.
- FSM states: RUN=0, STALL=1, FLUSH=2.
  - RUN: lu → STALL; else tk & br_nullify → FLUSH; else RUN.
  - STALL: lu → STALL (back-to-back dependent loads are legal); else tk & br_nullify → FLUSH; else RUN.
  - FLUSH: lu → STALL; else tk & br_nullify → FLUSH; else RUN.
  - State 3 unreachable; decodes as RUN.
- Outputs, combinational from current inputs (the FSM records history and counters only):
  - lu: LE=0, S=1, flush_ifid=0.
  - tk & br_nullify: LE=1, S=0, flush_ifid=1.
  - otherwise: LE=1, S=0, flush_ifid=0.
- Counters: stall_cnt += 1 on every edge with lu=1; flush_cnt += 1 on every edge with flush_ifid=1. Both saturate at 2^CNT_W−1 and do not wrap.
- Taken branch without nullify: no action; the delay slot executes.

## Timing
- Forwarding/LE/S/flush: zero-cycle combinational paths; they must settle within the same cycle as the stage registers.
- Load-use penalty is exactly 1 bubble per load. On the next cycle the load is in MEM and fw_x=10.
- Nullify penalty is exactly 1 squashed slot.
- state_out and counters update on the Clk edge after the event.
- Reset (Rst=0 at an edge):
  - state=RUN, stall_cnt=0, flush_cnt=0.
  - While Rst=0, outputs are forced: LE=1, S=1, flush_ifid=1, fw_a=fw_b=00. The pipeline fills with NOPs while PC advances from its reset value.
  - First edge with Rst=1: normal evaluation.
  - Reset asserted mid-STALL/FLUSH abandons the state with no residual bubble.

## Structure
- Shared package `pipe_pkg` holds:
  - FSM state encodings RUN/STALL/FLUSH;
  - forwarding-select constants FW_RF/FW_EX/FW_MEM/FW_WB;
  - NREG_W.
- One sub-module, `fwd_sel`, instantiated twice (operand a, b): inputs rx, use_x and the three stage rd/rf_le pairs plus ex_load; output the 2-bit select.
- The FSM and counters live in hazard_ctrl_unit.

## Test plan
- Reset: hold Rst=0 for 3 edges with random inputs → LE=1, S=1, flush_ifid=1, fw=00, counters 0, state_out=0. Release → RUN.
- Forward priority: id_ra=5, ex_rd=mem_rd=wb_rd=5, all rf_le=1, ex_load=0 → fw_a=01. Drop ex_rf_le → 10. Set id_ra=0 → 00.
- Load-use: ex_load=1, ex_rd=7, id_rb=7, id_use_b=1 → LE=0, S=1 for one cycle, state_out=1, stall_cnt=1. Next cycle mem_rd=7 → fw_b=10, LE=1.
- Nullify: br_taken=1, br_nullify=1, no hazard → flush_ifid=1, LE=1, state_out=2, flush_cnt=1. With br_nullify=0 → no flush.
- Simultaneous: br_taken=1, br_nullify=1 plus a branch-operand hazard on EX r3 → stall only, flush_cnt unchanged. Next cycle without hazard → flush.
- Saturation: CNT_W=2, 5 consecutive stalls → stall_cnt=3. Rst=0 mid-STALL → state 0, next cycle LE=1.
